// File: rtl/shift_seq_ctrl.sv
// Purpose: rate-selectable shift strobe (o_valid) and shift-direction owner for the LED shift register.
// Latency: o_valid registers one cycle after the prescaler compare; o_dir/o_step update on that same edge.
// Backpressure: none from downstream; i_enable freezes the prescaler (HOLD) and i_clear returns to IDLE.
module shift_seq_ctrl #(
    parameter int unsigned NB_CNT  = 32,
    parameter int unsigned RATE0   = 50_000_000,
    parameter int unsigned RATE1   = 25_000_000,
    parameter int unsigned RATE2   = 12_500_000,
    parameter int unsigned RATE3   = 6_250_000,
    parameter int unsigned N_STEPS = 4,
    parameter int unsigned NB_STEP = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic [1:0]         i_sel_rate,
    input  logic               i_btn_dir,
    input  logic               i_auto,
    output logic               o_valid,
    output logic               o_dir,
    output logic [1:0]         o_state,
    output logic [NB_STEP-1:0] o_step
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [NB_STEP-1:0] STEP_LAST = NB_STEP'(N_STEPS - 1);

    state_t               state_q, state_d;
    logic [NB_CNT-1:0]    cnt_q, cnt_d;
    logic [NB_CNT-1:0]    limit_m1;
    logic [NB_STEP-1:0]   step_q, step_d;
    logic                 valid_q, valid_d;
    logic                 dir_q, dir_d;
    logic                 btn_prev_q, btn_prev_d;
    logic                 advance;
    logic                 strobe;
    logic                 btn_edge;
    logic                 auto_wrap;

    // Terminal count for the selected rate; a new selection applies on the very next compare.
    always_comb begin
        case (i_sel_rate)
            2'b00:   limit_m1 = NB_CNT'(RATE0 - 1);
            2'b01:   limit_m1 = NB_CNT'(RATE1 - 1);
            2'b10:   limit_m1 = NB_CNT'(RATE2 - 1);
            default: limit_m1 = NB_CNT'(RATE3 - 1);
        endcase
    end

    // Next-state logic for the run/hold FSM, prescaler, step counter and direction.
    always_comb begin
        // The prescaler only advances on cycles that stay in RUN, so a strobe never lands in HOLD/IDLE.
        advance   = (state_q == ST_RUN) && i_enable && !i_clear;
        // >= rather than == so a rate drop below the current count fires immediately.
        strobe    = advance && (cnt_q >= limit_m1);
        btn_edge  = i_btn_dir && !btn_prev_q;
        auto_wrap = strobe && i_auto && (step_q == STEP_LAST);

        state_d = state_q;
        if (i_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (i_enable)  state_d = ST_RUN;
                ST_RUN:  if (!i_enable) state_d = ST_HOLD;
                ST_HOLD: if (i_enable)  state_d = ST_RUN;
                default:                state_d = ST_IDLE;
            endcase
        end

        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = strobe ? '0 : cnt_q + NB_CNT'(1);
        end

        // Button edge and auto wrap coincide into a single toggle.
        dir_d = dir_q ^ (btn_edge || auto_wrap);

        step_d = step_q;
        if (i_clear || btn_edge || auto_wrap) begin
            step_d = '0;
        end else if (strobe && i_auto) begin
            step_d = step_q + NB_STEP'(1);
        end

        valid_d    = strobe;
        btn_prev_d = i_btn_dir;
    end

    // Single register bank; synchronous reset overrides every other input.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            step_q     <= '0;
            valid_q    <= 1'b0;
            dir_q      <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            valid_q    <= valid_d;
            dir_q      <= dir_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign o_valid = valid_q;
    assign o_dir   = dir_q;
    assign o_state = state_q;
    assign o_step  = step_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Purpose: self-checking bench for shift_seq_ctrl with small rates and N_STEPS=3.
// Latency: outputs compared every cycle at the falling edge against an in-bench behavioural model.
// Backpressure: not applicable; stimulus is directed scenarios followed by randomized inputs.
module tb_shift_seq_ctrl;

    localparam int N_STEPS = 3;
    localparam int NB_STEP = 8;

    logic               clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_enable = 1'b0;
    logic               i_clear = 1'b0;
    logic [1:0]         i_sel_rate = 2'b00;
    logic               i_btn_dir = 1'b0;
    logic               i_auto = 1'b0;
    logic               o_valid;
    logic               o_dir;
    logic [1:0]         o_state;
    logic [NB_STEP-1:0] o_step;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk_en = 1'b0;

    // model state: state 0=IDLE 1=RUN 2=HOLD; clocks elapsed in current period; auto strobes in direction
    int  m_state, m_cnt, m_step;
    bit  m_valid, m_dir, m_btn_prev;

    shift_seq_ctrl #(
        .NB_CNT(32), .RATE0(4), .RATE1(8), .RATE2(2), .RATE3(1),
        .N_STEPS(N_STEPS), .NB_STEP(NB_STEP)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_clear),
        .i_sel_rate(i_sel_rate), .i_btn_dir(i_btn_dir), .i_auto(i_auto),
        .o_valid(o_valid), .o_dir(o_dir), .o_state(o_state), .o_step(o_step)
    );

    always #5 clk = ~clk;

    function automatic int rate_of(input logic [1:0] s);
        case (s)
            2'b00:   return 4;
            2'b01:   return 8;
            2'b10:   return 2;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: a strobe is due once a full period of L clocks has been spent in RUN.
    always @(posedge clk) begin : model
        int  lim;
        bit  running, fire, rise, wrap;
        if (i_reset) begin
            m_state = 0; m_cnt = 0; m_step = 0;
            m_valid = 0; m_dir = 0; m_btn_prev = 0;
        end else begin
            lim     = rate_of(i_sel_rate);
            rise    = i_btn_dir && !m_btn_prev;
            running = (m_state == 1) && i_enable && !i_clear;
            fire    = running && (m_cnt + 1 >= lim);
            wrap    = 0;
            m_valid = fire;
            if (i_clear)      m_cnt = 0;
            else if (running) m_cnt = fire ? 0 : m_cnt + 1;
            if (fire && i_auto) begin
                m_step = (m_step + 1) % N_STEPS;
                wrap   = (m_step == 0);
            end
            if (rise || wrap)         m_dir = !m_dir;
            if (i_clear || rise)      m_step = 0;
            if (i_clear)              m_state = 0;
            else if (m_state == 1)    m_state = i_enable ? 1 : 2;
            else if (i_enable)        m_state = 1;
            m_btn_prev = i_btn_dir;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_valid", int'(o_valid), int'(m_valid));
            check("cyc_dir",   int'(o_dir),   int'(m_dir));
            check("cyc_state", int'(o_state), m_state);
            check("cyc_step",  int'(o_step),  m_step);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Advance until o_valid is seen; n is the number of clocks taken (max+1 flags a timeout).
    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_valid && n <= max);
        if (!o_valid) $display("FAIL wait_valid: no strobe within %0d clocks", max);
    endtask

    initial begin
        int n;
        bit d0;

        // 1: reset, then run at RATE0=4
        tick(); chk_en = 1'b1; tick();
        check("rst_state", int'(o_state), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_dir",   int'(o_dir),   0);
        check("rst_step",  int'(o_step),  0);
        i_reset = 0; i_enable = 1; i_sel_rate = 2'b00;
        tick();
        check("run_entry_state", int'(o_state), 1);
        wait_valid(20, n); check("first_strobe_lat", n, 4);
        wait_valid(20, n); check("period_rate0", n, 4);

        // 2: hold after 2 clocks of a period for 5 clocks, then resume
        tick(); tick();
        i_enable = 0;
        for (int i = 0; i < 5; i++) tick();
        check("hold_state", int'(o_state), 2);
        i_enable = 1;
        tick();
        check("resume_state", int'(o_state), 1);
        wait_valid(20, n); check("resume_to_strobe", n, 2);

        // 3: switch to RATE1, at cnt=6 switch to RATE2 -> immediate strobe then period 2
        i_sel_rate = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        i_sel_rate = 2'b10;
        wait_valid(20, n); check("rate_drop_strobe", n, 1);
        wait_valid(20, n); check("period_rate2", n, 2);

        // 4: auto reverse every 3 strobes at RATE0
        i_sel_rate = 2'b00; i_auto = 1;
        d0 = o_dir;
        check("auto_step0", int'(o_step), 0);
        wait_valid(20, n); check("auto_step1", int'(o_step), 1);
        wait_valid(20, n); check("auto_step2", int'(o_step), 2);
        check("auto_dir_kept", int'(o_dir), int'(d0));
        wait_valid(20, n); check("auto_step_wrap", int'(o_step), 0);
        check("auto_dir_toggle", int'(o_dir), int'(!d0));

        // 5: button edge coincident with the 3rd auto strobe -> single toggle
        wait_valid(20, n); wait_valid(20, n);
        check("pre_coinc_step", int'(o_step), 2);
        d0 = o_dir;
        tick(); tick(); tick();
        i_btn_dir = 1;
        tick();
        check("coinc_valid", int'(o_valid), 1);
        check("coinc_dir",   int'(o_dir),   int'(!d0));
        check("coinc_step",  int'(o_step),  0);
        i_btn_dir = 0;
        tick();

        // 6: clear keeps direction; reset zeroes it
        i_btn_dir = 1; tick(); i_btn_dir = 0; tick();
        check("dir_before_clear", int'(o_dir), 1);
        i_clear = 1;
        tick();
        check("clr_state", int'(o_state), 0);
        check("clr_valid", int'(o_valid), 0);
        check("clr_dir",   int'(o_dir),   1);
        check("clr_step",  int'(o_step),  0);
        i_clear = 0;
        tick(); tick(); tick();
        i_reset = 1;
        tick();
        check("rst2_state", int'(o_state), 0);
        check("rst2_valid", int'(o_valid), 0);
        check("rst2_dir",   int'(o_dir),   0);
        i_reset = 0;

        // randomized phase, checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            i_reset = ($urandom_range(0, 299) == 0);
            i_clear = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) i_enable   = !i_enable;
            if ($urandom_range(0, 39) == 0) i_sel_rate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) i_btn_dir  = !i_btn_dir;
            if ($urandom_range(0, 99) == 0) i_auto     = !i_auto;
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
